// File: rtl/mmss_pkg.sv
// Shared definitions for the mm:ss timekeeping block: mode encoding, BCD digit
// limits and a two-digit BCD increment helper.
package mmss_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_PAUSE   = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_SEC = 2'd3
  } mode_e;

  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] UNITS_MAX    = 4'd9;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef struct packed {
    digit_t tens;
    digit_t units;
  } bcd_pair_t;

  function automatic logic pair_max(bcd_pair_t p);
    return (p.tens == SEC_TENS_MAX) && (p.units == UNITS_MAX);
  endfunction

  // 00..59 increment with wrap; minutes and seconds share the same limits.
  function automatic bcd_pair_t pair_inc(bcd_pair_t p);
    bcd_pair_t r;
    r = p;
    if (p.units == UNITS_MAX) begin
      r.units = '0;
      r.tens  = (p.tens == SEC_TENS_MAX) ? '0 : p.tens + 4'd1;
    end else begin
      r.units = p.units + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mmss_counter_btn_event.sv
// Button front end: synchronizer, optional stability filter (MMSS_DEBOUNCE_EN),
// and a rising-edge detector producing a one-cycle event.
module btn_event #(
  parameter int SYNC_STAGES = 2
`ifdef MMSS_DEBOUNCE_EN
  , parameter int DEB_CYCLES = 1000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   level;
  logic                   prev;

  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], btn};

`ifdef MMSS_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  logic [CW-1:0] cnt;
  logic          stable;

  // Accept the new level only once it has disagreed for DEB_CYCLES straight cycles.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync[SYNC_STAGES-1] == stable) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES-1)) begin
      stable <= sync[SYNC_STAGES-1];
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end

  assign level = stable;
`else
  assign level = sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) prev <= 1'b0;
    else     prev <= level;

  assign pulse = level & ~prev;

endmodule

// File: rtl/mmss_counter.sv
// mm:ss BCD timekeeper with run/pause and manual set modes feeding the 4-digit
// display driver. Optional button debounce is enabled by MMSS_DEBOUNCE_EN.
module mmss_counter
  import mmss_pkg::*;
#(
  parameter int TICK_DIV    = 50000000,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_btn,
  input  logic       set_btn,
  input  logic       inc_btn,
  output logic [3:0] mX,
  output logic [3:0] mU,
  output logic [3:0] sX,
  output logic [3:0] sU,
  output logic       hour_pulse,
  output logic [1:0] mode
);

  localparam int NUM_BTN = 3;
  localparam int BTN_RUN = 0;
  localparam int BTN_SET = 1;
  localparam int BTN_INC = 2;
  localparam int PW      = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] ev;

  assign btn_raw = {inc_btn, set_btn, run_btn};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_event #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef MMSS_DEBOUNCE_EN
      , .DEB_CYCLES(DEB_CYCLES)
`endif
    ) u_btn (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_raw[i]),
      .pulse(ev[i])
    );
  end

  mode_e     state, nxt;
  logic [PW-1:0] pre;
  logic      tick;
  bcd_pair_t mins, secs;

  // Prescaler only advances in RUN, so a resume always waits a full TICK_DIV.
  assign tick = (state == MODE_RUN) && (pre == PW'(TICK_DIV-1));

  always_ff @(posedge clk or posedge rst)
    if (rst)                                pre <= '0;
    else if (state != MODE_RUN || tick)     pre <= '0;
    else                                    pre <= pre + 1'b1;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= MODE_PAUSE;
    else     state <= nxt;

  // set takes priority over run when both fire together
  always_comb begin
    nxt = state;
    case (state)
      MODE_RUN:     if (ev[BTN_SET]) nxt = MODE_SET_MIN;
                    else if (ev[BTN_RUN]) nxt = MODE_PAUSE;
      MODE_PAUSE:   if (ev[BTN_SET]) nxt = MODE_SET_MIN;
                    else if (ev[BTN_RUN]) nxt = MODE_RUN;
      MODE_SET_MIN: if (ev[BTN_SET]) nxt = MODE_SET_SEC;
      MODE_SET_SEC: if (ev[BTN_SET]) nxt = MODE_PAUSE;
      default:      nxt = MODE_PAUSE;
    endcase
  end

  always_comb mode = state;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mins       <= '0;
      secs       <= '0;
      hour_pulse <= 1'b0;
    end else begin
      hour_pulse <= 1'b0;
      if (tick) begin
        secs <= pair_inc(secs);
        if (pair_max(secs)) begin
          mins       <= pair_inc(mins);
          hour_pulse <= pair_max(mins);
        end
      end else if (state == MODE_SET_MIN && ev[BTN_INC]) begin
        mins <= pair_inc(mins);
      end else if (state == MODE_SET_SEC && ev[BTN_INC]) begin
        secs <= pair_inc(secs);
      end
    end

  assign {mX, mU} = mins;
  assign {sX, sU} = secs;

endmodule

// File: tb/tb_mmss_counter.sv
// Scoreboard bench for mmss_counter: expected display/mode snapshots are queued
// as stimulus is applied and popped when the DUT state is sampled.
module tb_mmss_counter;

  localparam int TICK_DIV    = 4;
  localparam int SYNC_STAGES = 2;
  localparam int DEB_CYCLES  = 8;
`ifdef MMSS_DEBOUNCE_EN
  localparam int LAT = SYNC_STAGES + DEB_CYCLES + 1;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif
  localparam int M_RUN = 0, M_PAUSE = 1, M_SMIN = 2, M_SSEC = 3;
  localparam int B_RUN = 0, B_SET = 1, B_INC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_btn = 1'b0, set_btn = 1'b0, inc_btn = 1'b0;
  logic [3:0] mX, mU, sX, sU;
  logic       hour_pulse;
  logic [1:0] mode;

  mmss_counter #(
    .TICK_DIV(TICK_DIV), .SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .run_btn(run_btn), .set_btn(set_btn), .inc_btn(inc_btn),
    .mX(mX), .mU(mU), .sX(sX), .sU(sU), .hour_pulse(hour_pulse), .mode(mode)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {mode, mX, mU, sX, sU, hour_pulse};

  typedef struct {
    string       name;
    logic [18:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [18:0] enc(int md, int mm, int ss, int hp);
    return {2'(md), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 1'(hp)};
  endfunction

  task automatic push_exp(string name, int md, int mm, int ss, int hp = 0);
    exp_t x;
    x.name = name;
    x.v    = enc(md, mm, ss, hp);
    sb.push_back(x);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(int b, logic val);
    case (b)
      B_RUN:   run_btn = val;
      B_SET:   set_btn = val;
      default: inc_btn = val;
    endcase
  endtask

  task automatic press(int b);
    drive(b, 1'b1);
    step(LAT);
    drive(b, 1'b0);
    step(LAT);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic set_time(int mm, int ss);
    press(B_SET);
    repeat (mm) press(B_INC);
    press(B_SET);
    repeat (ss) press(B_INC);
    press(B_SET);
  endtask

  task automatic test_reset();
    step(2);
    push_exp("reset_held", M_PAUSE, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    rst = 1'b0;
    step(3);
    push_exp("reset_released", M_PAUSE, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

  task automatic test_run_count();
    run_btn = 1'b1;
    step(LAT);
    push_exp("run_enter", M_RUN, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    run_btn = 1'b0;
    step(4);
    push_exp("first_tick", M_RUN, 0, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    step(4);
    push_exp("second_tick", M_RUN, 0, 2);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    // pause lands LAT cycles after this press; ticks up to and including that edge count
    press(B_RUN);
    step(20);
    push_exp("paused_frozen", M_PAUSE, 0, (8 + LAT) / TICK_DIV);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

  task automatic test_min_carry();
    do_reset();
    set_time(9, 59);
    push_exp("preload_0959", M_PAUSE, 9, 59);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    run_btn = 1'b1;
    step(LAT);
    run_btn = 1'b0;
    step(3);
    push_exp("before_carry", M_RUN, 9, 59);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    step(1);
    push_exp("carry_1000", M_RUN, 10, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

  task automatic test_hour_wrap();
    do_reset();
    set_time(59, 58);
    run_btn = 1'b1;
    step(LAT);
    run_btn = 1'b0;
    step(4);
    push_exp("at_5959", M_RUN, 59, 59, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    step(4);
    push_exp("wrap_pulse", M_RUN, 0, 0, 1);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    step(1);
    push_exp("pulse_cleared", M_RUN, 0, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

  task automatic test_set_modes();
    do_reset();
    press(B_INC);
    push_exp("inc_in_pause", M_PAUSE, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    press(B_SET);
    push_exp("enter_set_min", M_SMIN, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    repeat (61) press(B_INC);
    push_exp("min_wrap_61", M_SMIN, 1, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    press(B_SET);
    repeat (3) press(B_INC);
    push_exp("sec_inc_3", M_SSEC, 1, 3);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    press(B_SET);
    push_exp("back_to_pause", M_PAUSE, 1, 3);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_btn = 1'b1;
    step(LAT + 20);
    set_btn = 1'b0;
    step(LAT);
    push_exp("held_one_event", M_SMIN, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    set_btn = 1'b1;
    inc_btn = 1'b1;
    step(LAT);
    set_btn = 1'b0;
    inc_btn = 1'b0;
    step(LAT);
    push_exp("inc_with_set", M_SSEC, 1, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

  task automatic test_run_set_same();
    do_reset();
    run_btn = 1'b1;
    step(LAT);
    run_btn = 1'b0;
    step(LAT);
    run_btn = 1'b1;
    set_btn = 1'b1;
    step(LAT);
    push_exp("run_set_same", M_SMIN, 0, (2 * LAT) / TICK_DIV);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    run_btn = 1'b0;
    set_btn = 1'b0;
    step(20);
    push_exp("set_min_frozen", M_SMIN, 0, (2 * LAT) / TICK_DIV);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_time(12, 33);
    run_btn = 1'b1;
    step(LAT);
    run_btn = 1'b0;
    step(5);
    push_exp("at_1234", M_RUN, 12, 34);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    #2 rst = 1'b1;
    #1;
    push_exp("async_reset", M_PAUSE, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    rst = 1'b0;
    step(1);
    run_btn = 1'b1;
    step(1);
    rst = 1'b1;
    run_btn = 1'b0;
    step(2);
    rst = 1'b0;
    step(LAT + 4);
    push_exp("no_pending_event", M_PAUSE, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

`ifdef MMSS_DEBOUNCE_EN
  task automatic test_debounce();
    do_reset();
    press(B_SET);
    inc_btn = 1'b1;
    step(5);
    inc_btn = 1'b0;
    step(20);
    push_exp("glitch_rejected", M_SMIN, 0, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
    inc_btn = 1'b1;
    step(12);
    inc_btn = 1'b0;
    step(20);
    push_exp("long_pulse_once", M_SMIN, 1, 0);
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask
`endif

  initial begin
    test_reset();
    test_run_count();
    test_min_carry();
    test_hour_wrap();
    test_set_modes();
    test_back_to_back();
    test_run_set_same();
    test_reset_mid();
`ifdef MMSS_DEBOUNCE_EN
    test_debounce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmss_counter.md
Name: mmss_counter

Overview:
- Timekeeping stage directly upstream of the 4-digit multiplexed seven-segment display driver.
- Produces four registered BCD digits (minute tens/units, second tens/units) consumed by that driver.
- Counts seconds from a prescaled system clock.
- Three push-buttons provide run/pause and manual minute/second setting through a small mode FSM.

Parameters:
- TICK_DIV, 50000000, system-clock cycles per one-second tick; legal range ≥2.
- SYNC_STAGES, 2, flip-flop stages in each button synchronizer; legal range ≥2.
- DEB_CYCLES, 1000000, cycles a button level must stay stable before acceptance; used only with DEBOUNCE_EN.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- run_btn  in  1  asynchronous button; toggles RUN/PAUSE.
- set_btn  in  1  asynchronous button; advances setting mode.
- inc_btn  in  1  asynchronous button; increments the selected field in setting modes.
- mX  out  4  minute tens, BCD 0..5.
- mU  out  4  minute units, BCD 0..9.
- sX  out  4  second tens, BCD 0..5.
- sU  out  4  second units, BCD 0..9.
- hour_pulse  out  1  one-cycle pulse on the 59:59 -> 00:00 wrap in RUN.
- mode  out  2  current FSM state: 0 = RUN, 1 = PAUSE, 2 = SET_MIN, 3 = SET_SEC.

Behaviour:
- Reset (asynchronous, active-high):
  - All digits = 0.
  - hour_pulse = 0; mode = PAUSE.
  - Prescaler = 0; synchronizer and edge registers = 0.
- Buttons:
  - Each button passes through a SYNC_STAGES-deep synchronizer, then a rising-edge detector.
  - The detector emits a one-cycle event pulse.
  - The pulse appears SYNC_STAGES+1 cycles after the input rises.
  - A held button yields exactly one event.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN only; tick = (count == TICK_DIV-1), then count returns to 0.
  - Forced to 0 on any cycle where mode != RUN, so the first tick after resuming comes TICK_DIV cycles later.
- RUN counting:
  - On tick, sU increments; 9 -> 0 carries to sX.
  - sX 5 -> 0 carries to mU; mU 9 -> 0 carries to mX; mX 5 -> 0 wraps.
  - At 59:59, a tick produces 00:00 and hour_pulse = 1 for exactly that one cycle.
  - Digits update on the clock edge where tick is high; outputs are registered (latency 1 from tick).
- FSM transitions, evaluated on event pulses:
  - RUN + run -> PAUSE; PAUSE + run -> RUN.
  - RUN or PAUSE + set -> SET_MIN; SET_MIN + set -> SET_SEC; SET_SEC + set -> PAUSE.
  - run ignored in SET_MIN/SET_SEC.
  - Simultaneous run and set events: set wins; run is discarded.
- Setting modes:
  - SET_MIN + inc: minutes +1 as a BCD pair, 59 -> 00; seconds unchanged; no hour_pulse.
  - SET_SEC + inc: seconds +1, 59 -> 00; no carry into minutes; no hour_pulse.
  - inc is ignored in RUN and PAUSE.
  - Simultaneous inc and set: the increment applies to the current field, then the mode changes, both on the same edge.
- Invariant: digits never leave their BCD ranges. No illegal-value recovery is needed beyond reset.
- Reset mid-count or mid-setting: immediate return to the reset state; no pending event survives.

Optional Feature:
- Macro: MMSS_DEBOUNCE_EN.
- Defined: after synchronization, each button passes through a stability filter before edge detection.
  - The accepted level changes only after the raw synchronized level has differed from it for DEB_CYCLES consecutive cycles.
  - Event latency becomes SYNC_STAGES+DEB_CYCLES+1.
  - Glitches shorter than DEB_CYCLES produce no event.
- Undefined: no filter; DEB_CYCLES is unused; latency is SYNC_STAGES+1.

Decomposition:
- Shared package mmss_pkg:
  - mode encoding constants MODE_RUN/PAUSE/SET_MIN/SET_SEC;
  - digit limits SEC_TENS_MAX = 5 and UNITS_MAX = 9;
  - the 4-bit BCD digit width.
- One sub-module, btn_event:
  - synchronizer, optional debounce filter, rising-edge pulse;
  - instantiated three times.
- The BCD cascade and FSM stay in mmss_counter.

Test Plan (TICK_DIV = 4, SYNC_STAGES = 2, DEBOUNCE disabled unless stated):
- Reset then run press -> mode = RUN 3 cycles after press. sU = 1 after 4 more cycles; sU = 2 after 8.
- Preload 09:59 via set/inc, then RUN -> next tick gives 10:00; no hour_pulse.
- Preload 59:58, RUN -> 59:59, then 00:00 with hour_pulse high for exactly 1 cycle.
- Set_btn from PAUSE then inc x61 -> minutes read 01 (wraps once at 59 -> 00); seconds unchanged. Set again, inc x3 -> seconds 03. Set -> mode = PAUSE.
- Run and set asserted on the same cycle in RUN -> mode = SET_MIN; prescaler held 0; digits frozen.
- Assert rst mid-count at 12:34 -> outputs read 00:00 and mode = PAUSE in the same cycle without a clock edge.
- With MMSS_DEBOUNCE_EN and DEB_CYCLES = 8: a 5-cycle pulse on inc_btn gives no increment; a 12-cycle pulse gives exactly one.
